// File: rtl/prescaled_digit_counter_pkg.sv
// Shared definitions for the prescaled digit counter and its digit cells.
package prescaled_digit_counter_pkg;

    // Every digit is one BCD-style nibble.
    localparam int DIGIT_W = 4;

    // Count direction of the digit cascade.
    typedef enum logic {
        MODE_UP   = 1'b0,
        MODE_DOWN = 1'b1
    } mode_e;

    // Width of the shifted compare value: the 8-bit switch value plus the shift.
    function automatic int cmp_width(input int cnt_w, input int cmp_shift);
        int w;
        w = cmp_shift + 8;
        if (w > cnt_w) begin
            w = cnt_w;
        end
        return w;
    endfunction

endpackage

// File: rtl/prescaled_digit_counter_digit.sv
// One modular up/down digit; wrap_out feeds the next digit's step_in.
module digit_cell
    import prescaled_digit_counter_pkg::*;
#(
    parameter int DIG_MAX = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               step_in,
    input  mode_e              mode,
    output logic [DIGIT_W-1:0] value,
    output logic               wrap_out
);

    localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(DIG_MAX);

    // The digit wraps on this edge when it is stepped while sitting at its end value.
    assign wrap_out = step_in && ((mode == MODE_UP) ? (value == TOP) : (value == '0));

    // Step the digit one position in the requested direction, wrapping at 0 / DIG_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (step_in) begin
            if (mode == MODE_UP) begin
                value <= (value == TOP) ? '0 : value + DIGIT_W'(1);
            end else begin
                value <= (value == '0) ? TOP : value - DIGIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/prescaled_digit_counter.sv
// Programmable prescaler driving a cascade of modulo-(DIG_MAX+1) digits.
module prescaled_digit_counter
    import prescaled_digit_counter_pkg::*;
#(
    parameter int CNT_W     = 24,
    parameter int CMP_SHIFT = 10,
    parameter int DIGITS    = 2,
    parameter int DIG_MAX   = 9
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic [7:0]                cmp_in,
    input  logic                      mode_down,
    input  logic                      hold,
    input  logic                      clear,
    output logic                      tick,
    output logic [DIGIT_W*DIGITS-1:0] digits,
    output logic                      carry_out,
    output logic [7:0]                presc_low
);

    localparam int CMP_W = cmp_width(CNT_W, CMP_SHIFT);

    logic [CNT_W-1:0] presc;
    logic [CMP_W-1:0] cmp_full;
    logic [CNT_W-1:0] compare;
    logic             run;
    logic             wrap_now;
    logic [DIGITS:0]  step;
    mode_e            mode_sel;

    // Compare value is the switch byte shifted up; a value of zero ticks every cycle.
    assign cmp_full = CMP_W'(cmp_in) << CMP_SHIFT;
    assign compare  = CNT_W'(cmp_full);

    // Counting happens only when enabled and not held; clear overrides both.
    assign run      = ena && !hold;
    assign wrap_now = presc >= compare;
    assign mode_sel = mode_down ? MODE_DOWN : MODE_UP;
    assign step[0]  = !clear && run && wrap_now;

    // Digit cascade: each digit steps only when the one below it wraps on the same edge.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        digit_cell #(
            .DIG_MAX(DIG_MAX)
        ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (clear),
            .step_in (step[k]),
            .mode    (mode_sel),
            .value   (digits[k*DIGIT_W +: DIGIT_W]),
            .wrap_out(step[k+1])
        );
    end

    // Prescaler with >= wrap so lowering cmp_in below the count wraps right away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            tick      <= 1'b0;
            carry_out <= 1'b0;
        end else if (clear) begin
            presc     <= '0;
            tick      <= 1'b0;
            carry_out <= 1'b0;
        end else if (!run) begin
            tick      <= 1'b0;
            carry_out <= 1'b0;
        end else if (wrap_now) begin
            presc     <= '0;
            tick      <= 1'b1;
            carry_out <= step[DIGITS];
        end else begin
            presc     <= presc + CNT_W'(1);
            tick      <= 1'b0;
            carry_out <= 1'b0;
        end
    end

    assign presc_low = presc[7:0];

endmodule

// File: tb/tb_prescaled_digit_counter.sv
// Randomized and directed bench for prescaled_digit_counter against a count-value model.
module tb_prescaled_digit_counter;

    localparam int CNT_W     = 24;
    localparam int CMP_SHIFT = 10;
    localparam int DIGITS    = 2;
    localparam int DIG_MAX   = 9;
    localparam int BASE      = DIG_MAX + 1;

    logic                clk;
    logic                rst_n;
    logic                ena;
    logic [7:0]          cmp_in;
    logic                mode_down;
    logic                hold;
    logic                clear;
    logic                tick;
    logic [4*DIGITS-1:0] digits;
    logic                carry_out;
    logic [7:0]          presc_low;

    int checks;
    int errors;

    // Reference model: whole cascade as a single integer modulo BASE**DIGITS.
    int m_presc;
    int m_count;
    int m_tick;
    int m_carry;
    int total;

    prescaled_digit_counter #(
        .CNT_W    (CNT_W),
        .CMP_SHIFT(CMP_SHIFT),
        .DIGITS   (DIGITS),
        .DIG_MAX  (DIG_MAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .cmp_in   (cmp_in),
        .mode_down(mode_down),
        .hold     (hold),
        .clear    (clear),
        .tick     (tick),
        .digits   (digits),
        .carry_out(carry_out),
        .presc_low(presc_low)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] packCount(input int c);
        logic [4*DIGITS-1:0] p;
        int rest;
        p = '0;
        rest = c;
        for (int k = 0; k < DIGITS; k++) begin
            p[4*k +: 4] = 4'(rest % BASE);
            rest = rest / BASE;
        end
        return p;
    endfunction

    task automatic modelReset();
        m_presc = 0;
        m_count = 0;
        m_tick  = 0;
        m_carry = 0;
    endtask

    // Apply the rules with the inputs present at the clock edge.
    task automatic modelEdge();
        int cmp_val;
        cmp_val = int'(cmp_in) * (1 << CMP_SHIFT);
        if (clear) begin
            modelReset();
        end else if (hold || !ena) begin
            m_tick  = 0;
            m_carry = 0;
        end else if (m_presc >= cmp_val) begin
            m_presc = 0;
            m_tick  = 1;
            m_carry = 0;
            if (mode_down) begin
                if (m_count == 0) begin
                    m_count = total - 1;
                    m_carry = 1;
                end else begin
                    m_count = m_count - 1;
                end
            end else begin
                if (m_count == total - 1) begin
                    m_count = 0;
                    m_carry = 1;
                end else begin
                    m_count = m_count + 1;
                end
            end
        end else begin
            m_presc = m_presc + 1;
            m_tick  = 0;
            m_carry = 0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] c, input logic h, input logic e,
                                 input logic md, input logic cl);
        cmp_in    = c;
        hold      = h;
        ena       = e;
        mode_down = md;
        clear     = cl;
    endtask

    task automatic compareAll();
        checkOutput("digits", 32'(digits), 32'(packCount(m_count)));
        checkOutput("tick", 32'(tick), 32'(m_tick));
        checkOutput("carry_out", 32'(carry_out), 32'(m_carry));
        checkOutput("presc_low", 32'(presc_low), 32'(m_presc % 256));
    endtask

    task automatic runCycle();
        @(posedge clk);
        modelEdge();
        #1;
        compareAll();
    endtask

    initial begin
        logic [4*DIGITS-1:0] held_digits;
        logic [7:0]          held_low;
        logic                md;
        int                  carries;
        int                  period;
        int                  wraps;
        int                  prev_low;
        bit                  found;

        checks = 0;
        errors = 0;
        total  = 1;
        for (int k = 0; k < DIGITS; k++) total = total * BASE;

        // Power-up reset
        applyStimulus(8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        modelReset();
        #12;
        compareAll();
        rst_n = 1'b1;

        // Count up at full rate through one complete cascade wrap
        applyStimulus(8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        runCycle();
        applyStimulus(8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        carries = 0;
        for (int i = 0; i < total; i++) begin
            runCycle();
            if (carry_out) carries++;
        end
        checkOutput("t2_carry_count", 32'(carries), 32'd1);
        checkOutput("t2_wrapped_digits", 32'(digits), 32'h00);

        // Down from 00 borrows into 99 then steps to 98
        applyStimulus(8'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        runCycle();
        applyStimulus(8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        runCycle();
        checkOutput("t4_digits_99", 32'(digits), 32'h99);
        checkOutput("t4_borrow", 32'(carry_out), 32'd1);
        runCycle();
        checkOutput("t4_digits_98", 32'(digits), 32'h98);
        checkOutput("t4_no_borrow", 32'(carry_out), 32'd0);

        // Hold for 50 cycles, then clear while still held
        applyStimulus(8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) runCycle();
        held_digits = digits;
        held_low    = presc_low;
        applyStimulus(8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            runCycle();
            checkOutput("t5_hold_digits", 32'(digits), 32'(held_digits));
            checkOutput("t5_hold_low", 32'(presc_low), 32'(held_low));
            checkOutput("t5_hold_tick", 32'(tick), 32'd0);
        end
        applyStimulus(8'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        runCycle();
        checkOutput("t5_clear_digits", 32'(digits), 32'h00);
        checkOutput("t5_clear_low", 32'(presc_low), 32'd0);

        // Period with cmp_in=1 is 1025 cycles with four 255->0 wraps of presc_low
        applyStimulus(8'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            runCycle();
            if (tick) found = 1'b1;
        end
        checkOutput("t3_first_tick", 32'(found), 32'd1);
        period   = 0;
        wraps    = 0;
        prev_low = int'(presc_low);
        found    = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            runCycle();
            period++;
            if (prev_low == 255 && presc_low == 8'd0) wraps++;
            prev_low = int'(presc_low);
            if (tick) found = 1'b1;
        end
        checkOutput("t3_second_tick", 32'(found), 32'd1);
        checkOutput("t3_period", 32'(period), 32'd1025);
        checkOutput("t3_low_wraps", 32'(wraps), 32'd4);

        // Lower the compare below the running prescaler: wraps on the next edge
        applyStimulus(8'd4, 1'b0, 1'b1, 1'b0, 1'b1);
        runCycle();
        applyStimulus(8'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) runCycle();
        checkOutput("t6_presc_low_3000", 32'(presc_low), 32'(3000 % 256));
        checkOutput("t6_digits_before", 32'(digits), 32'h00);
        applyStimulus(8'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        runCycle();
        checkOutput("t6_tick", 32'(tick), 32'd1);
        checkOutput("t6_presc_zero", 32'(presc_low), 32'd0);
        checkOutput("t6_digits_after", 32'(digits), 32'h01);

        // Randomized mix of enables, holds, clears, direction and compare changes
        md = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) md = ~md;
            applyStimulus(($urandom_range(0, 99) < 85) ? 8'd0 : 8'($urandom_range(0, 1)),
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 9) != 0,
                          md,
                          $urandom_range(0, 79) == 0);
            runCycle();
            // Asynchronous reset in the middle of a cycle
            if (i == 1500) begin
                #3;
                rst_n = 1'b0;
                modelReset();
                #1;
                checkOutput("t1_rst_digits", 32'(digits), 32'h00);
                checkOutput("t1_rst_tick", 32'(tick), 32'd0);
                checkOutput("t1_rst_carry", 32'(carry_out), 32'd0);
                checkOutput("t1_rst_low", 32'(presc_low), 32'd0);
                #1;
                rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prescaled_digit_counter.md
Name: prescaled_digit_counter

Overview:
Parametrised successor to the single-digit second counter in the async-proc top level. A programmable prescaler divides clk by a compare value taken from the input switches. Each prescaler wrap produces a one-cycle tick that advances a cascade of DIGITS modulo-(DIG_MAX+1) digits, counting up or down. The block drives the 7-seg and bidirectional outputs of the top level. It also serves as the tick source for the node array.

Parameters:
CNT_W, 24, prescaler counter width
CMP_SHIFT, 10, left shift applied to cmp_in to form the compare value; CMP_SHIFT+8 <= CNT_W
DIGITS, 2, number of cascaded digits (1..4)
DIG_MAX, 9, terminal value of every digit; legal range 1..15

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; low = freeze, same effect as hold
cmp_in  in  8  compare value = zero-extended {cmp_in, CMP_SHIFT zeros}
mode_down  in  1  0 = count up, 1 = count down
hold  in  1  freeze prescaler and digits
clear  in  1  synchronous clear of prescaler and digits
tick  out  1  one-cycle pulse on each prescaler wrap
digits  out  4*DIGITS  digit values; digit 0 in bits [3:0]
carry_out  out  1  one-cycle pulse when the whole cascade wraps (overflow up, underflow down)
presc_low  out  8  prescaler bits [7:0], for the uio pins

Behaviour:
- Reset: rst_n low asynchronously forces prescaler, digits, tick, carry_out and presc_low to 0. Release is synchronous to the next clk edge.
- Priority each edge: clear > (hold | !ena) > normal count.
- clear: prescaler <= 0, digits <= 0, tick <= 0, carry_out <= 0. Applies regardless of hold or ena.
- hold or !ena: all state holds. tick and carry_out are forced to 0.
- Normal count, prescaler: if prescaler >= compare, then prescaler <= 0 and tick <= 1; otherwise prescaler <= prescaler+1 and tick <= 0.
  - The comparison is >=, not ==. Lowering cmp_in below the current count wraps on the next edge.
  - compare = 0 gives a tick every enabled cycle.
- Period: compare+1 enabled cycles per tick.
- Digits: they update on the same edge that registers tick=1, so the new digit values and tick are visible together.
- Digit 0 steps on every tick. Digit k steps only when digit k-1 wraps on that same edge.
- Up mode: d == DIG_MAX → d <= 0 with carry; else d+1.
- Down mode: d == 0 → d <= DIG_MAX with borrow; else d-1.
- carry_out = carry or borrow out of the top digit. It is registered and coincident with tick.
- mode_down is sampled on each tick edge. Changing it between ticks takes effect on the next tick; no glitch or extra step.
- Digits never leave 0..DIG_MAX. Changing cmp_in never alters digits directly.
- Latency: tick/digits/carry_out are available one edge after the compare condition is sampled. presc_low mirrors the registered prescaler with no additional delay.
- All outputs are registered. There are no combinational input-to-output paths.

Decomposition:
- Package prescaled_digit_counter_pkg:
  - DIGIT_W = 4
  - mode enum {MODE_UP, MODE_DOWN}
  - function computing compare width from CNT_W/CMP_SHIFT
- Sub-module digit_cell: one modular up/down digit with step_in, mode, and clear inputs, and value and wrap_out outputs. It is parametrised by DIG_MAX and instantiated DIGITS times in a generate chain, with wrap_out feeding the next cell's step_in.
- Top module: prescaler, compare logic, enable/priority logic, output registers.

Test Plan:
1. Drive rst_n low mid-cycle during counting -> all outputs 0 before the next edge; count resumes from 00 after release.
2. cmp_in=0, up, DIGITS=2 -> tick every cycle; digits run 00,01..09,10..99,00; carry_out pulses once at the 99→00 edge (100th tick).
3. cmp_in=1 (compare=1024) -> tick period exactly 1025 cycles; presc_low wraps 255→0 four times between ticks.
4. mode_down=1 from 00, cmp_in=0 -> first tick gives 99 with carry_out=1; the next tick gives 98 with carry_out=0.
5. hold=1 for 50 cycles mid-count -> digits/presc_low constant, tick=0; then assert clear with hold=1 -> digits=00, presc_low=0 next edge.
6. cmp_in=4 (compare=4096), prescaler at 3000, change cmp_in to 1 -> tick on next edge, prescaler 0, digit 0 incremented by exactly 1.
